// File: rtl/wishbone_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin grant and
// bus locking for the whole CYC period. The registered grant selects a
// combinational mux of the granted master's signals towards the slave.
// Optional ACK watchdog: define ARB_TIMEOUT_EN to enable it.
module wishbone_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // Master 0
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_stb_i,
    input  logic            m0_cyc_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    // Master 1
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_stb_i,
    input  logic            m1_cyc_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    // Slave
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_stb_o,
    output logic            s_cyc_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    // Current grant, one-hot
    output logic [1:0]      gnt_o
);

    if (DW % 8 != 0) begin : g_bad_dw
        $error("DW must be a multiple of 8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;   // 1 = master 1 was served last

    logic   cur_stb;          // raw strobe of the granted master
    logic   stb_block;        // watchdog mask on the slave strobe
    logic   to_err;           // watchdog error pulse for the granted master

    // Grant state and round-robin pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Arbitration: hold while the owner keeps CYC, hand over directly on release
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (m0_cyc_i && m1_cyc_i) state_d = last_q ? StGnt0 : StGnt1;
                else if (m0_cyc_i)        state_d = StGnt0;
                else if (m1_cyc_i)        state_d = StGnt1;
            end
            StGnt0: begin
                if (!m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc_i ? StGnt1 : StIdle;
                end
            end
            StGnt1: begin
                if (!m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc_i ? StGnt0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobe of whichever master currently owns the bus
    always_comb begin
        cur_stb = 1'b0;
        unique case (state_q)
            StGnt0:  cur_stb = m0_stb_i;
            StGnt1:  cur_stb = m1_stb_i;
            default: cur_stb = 1'b0;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

    logic [15:0] cnt_q, cnt_d;
    logic        mask_q, mask_d;
    logic        granted;
    logic        to_hit;

    assign granted   = (state_q != StIdle);
    assign to_hit    = granted && (cnt_q == TimeoutVal);
    assign stb_block = mask_q || to_hit;
    // ACK wins over a simultaneous timeout
    assign to_err    = to_hit && !s_ack_i;

    // Watchdog counter and strobe mask
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            mask_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
        end
    end

    // Count stalled strobe cycles; clear on ACK, grant change, idle strobe or timeout
    always_comb begin
        cnt_d  = '0;
        mask_d = 1'b0;
        if (granted && (state_d == state_q) && cur_stb) begin
            if (!to_hit && !mask_q && !s_ack_i) cnt_d = cnt_q + 16'd1;
            // Mask stays until the master withdraws its strobe
            mask_d = mask_q || to_err;
        end
    end
`else
    assign stb_block = 1'b0;
    assign to_err    = 1'b0;
`endif

    // Output mux driven by the registered grant, forced quiet during reset
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        gnt_o    = 2'b00;
        unique case (state_q)
            StGnt0: begin
                gnt_o    = 2'b01;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_stb_o  = cur_stb && !stb_block;
                s_cyc_o  = m0_cyc_i;
                m0_ack_o = s_ack_i;
                m0_err_o = to_err;
            end
            StGnt1: begin
                gnt_o    = 2'b10;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_stb_o  = cur_stb && !stb_block;
                s_cyc_o  = m1_cyc_i;
                m1_ack_o = s_ack_i;
                m1_err_o = to_err;
            end
            default: ;
        endcase
        if (rst_i) begin
            s_cyc_o  = 1'b0;
            s_stb_o  = 1'b0;
            s_we_o   = 1'b0;
            m0_ack_o = 1'b0;
            m0_err_o = 1'b0;
            m1_ack_o = 1'b0;
            m1_err_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed self-checking bench for wishbone_arbiter (TIMEOUT = 8).
module tb_wishbone_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk_i, rst_i;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic          m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o, m0_err_o;
    logic          m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o, m1_err_o;
    logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
    logic          s_we_o, s_stb_o, s_cyc_o, s_ack_i;
    logic [1:0]    gnt_o;

    int n_pass  = 0;
    int n_total = 0;

    wishbone_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .gnt_o(gnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 0; m0_sel_i = '0; m0_stb_i = 0; m0_cyc_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 0; m1_sel_i = '0; m1_stb_i = 0; m1_cyc_i = 0;
        s_dat_i  = '0; s_ack_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1;
        step();
        step();
        rst_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1;
        step();
        step();
        #1;
        n_total++; if (gnt_o !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt_o); else n_pass++;
        n_total++; if (s_cyc_o !== 1'b0) $display("FAIL reset_cyc: got %b want 0", s_cyc_o); else n_pass++;
        n_total++;
        if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0)
            $display("FAIL reset_ack_err: got %b want 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
        else n_pass++;
        n_total++; if (s_adr_o !== '0) $display("FAIL reset_adr: got %h want 0", s_adr_o); else n_pass++;
        rst_i = 0;
        step();
        #1;
        n_total++; if (gnt_o !== 2'b00) $display("FAIL idle_gnt: got %b want 00", gnt_o); else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        m0_adr_i = 32'h10; m0_dat_i = 32'hA5A5A5A5; m0_sel_i = 4'hF; m0_we_i = 1;
        m0_cyc_i = 1; m0_stb_i = 1;
        #1;
        n_total++; if (s_cyc_o !== 1'b0) $display("FAIL single_latency: got %b want 0", s_cyc_o); else n_pass++;
        step();
        #1;
        n_total++; if (gnt_o !== 2'b01) $display("FAIL single_gnt: got %b want 01", gnt_o); else n_pass++;
        n_total++;
        if ({s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o} !== {32'h10, 32'hA5A5A5A5, 4'hF, 3'b111})
            $display("FAIL single_slave_bus: got adr=%h dat=%h sel=%h we/cyc/stb=%b%b%b want 10 A5A5A5A5 F 111",
                     s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o);
        else n_pass++;
        n_total++; if (m0_ack_o !== 1'b0) $display("FAIL single_early_ack: got %b want 0", m0_ack_o); else n_pass++;
        step();
        s_ack_i = 1;
        #1;
        n_total++;
        if ({m0_ack_o, m1_ack_o} !== 2'b10) $display("FAIL single_ack: got %b want 10", {m0_ack_o, m1_ack_o});
        else n_pass++;
        step();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        #1;
        n_total++; if (m0_ack_o !== 1'b0) $display("FAIL single_ack_pulse: got %b want 0", m0_ack_o); else n_pass++;
        step();
        #1;
        n_total++; if (gnt_o !== 2'b00) $display("FAIL single_release: got %b want 00", gnt_o); else n_pass++;
    endtask

    task automatic test_tie();
        do_reset();
        m0_adr_i = 32'h100; m1_adr_i = 32'h200;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        #1;
        n_total++; if (gnt_o !== 2'b01) $display("FAIL tie_first: got %b want 01", gnt_o); else n_pass++;
        n_total++; if (s_adr_o !== 32'h100) $display("FAIL tie_first_adr: got %h want 100", s_adr_o); else n_pass++;
        s_ack_i = 1; s_dat_i = 32'h1111_0000;
        #1;
        n_total++;
        if ({m0_ack_o, m1_ack_o} !== 2'b10) $display("FAIL tie_ack0: got %b want 10", {m0_ack_o, m1_ack_o});
        else n_pass++;
        n_total++; if (m0_dat_o !== 32'h1111_0000) $display("FAIL tie_dat0: got %h want 11110000", m0_dat_o); else n_pass++;
        step();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        step();
        #1;
        n_total++; if (gnt_o !== 2'b10) $display("FAIL tie_handover: got %b want 10", gnt_o); else n_pass++;
        n_total++; if (s_adr_o !== 32'h200) $display("FAIL tie_second_adr: got %h want 200", s_adr_o); else n_pass++;
        // ACK in the same cycle m1 drops CYC is still routed to m1
        s_ack_i = 1; m1_cyc_i = 0; m1_stb_i = 0;
        #1;
        n_total++;
        if ({m0_ack_o, m1_ack_o} !== 2'b01) $display("FAIL tie_late_ack1: got %b want 01", {m0_ack_o, m1_ack_o});
        else n_pass++;
        step();
        s_ack_i = 0;
        #1;
        n_total++; if (gnt_o !== 2'b00) $display("FAIL tie_idle: got %b want 00", gnt_o); else n_pass++;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        #1;
        n_total++; if (gnt_o !== 2'b01) $display("FAIL tie_second_round: got %b want 01", gnt_o); else n_pass++;
        clear_inputs();
        step();
    endtask

    task automatic test_lock();
        do_reset();
        m1_adr_i = 32'h300; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int i = 0; i < 4; i++) begin
            s_ack_i = 1;
            #1;
            n_total++; if (gnt_o !== 2'b10) $display("FAIL lock_gnt beat %0d: got %b want 10", i, gnt_o); else n_pass++;
            n_total++;
            if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0100)
                $display("FAIL lock_ack beat %0d: got %b want 0100", i, {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
            else n_pass++;
            step();
        end
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        #1;
        n_total++; if (gnt_o !== 2'b10) $display("FAIL lock_hold: got %b want 10", gnt_o); else n_pass++;
        step();
        #1;
        n_total++; if (gnt_o !== 2'b01) $display("FAIL lock_switch: got %b want 01", gnt_o); else n_pass++;
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
        step();
        #1;
        n_total++; if (s_cyc_o !== 1'b1) $display("FAIL rstmid_pre_cyc: got %b want 1", s_cyc_o); else n_pass++;
        rst_i = 1; s_ack_i = 1;
        #1;
        n_total++;
        if ({s_cyc_o, s_stb_o, s_we_o, m0_ack_o} !== 4'b0)
            $display("FAIL rstmid_quiet: got %b want 0000", {s_cyc_o, s_stb_o, s_we_o, m0_ack_o});
        else n_pass++;
        step();
        s_ack_i = 0;
        #1;
        n_total++; if (gnt_o !== 2'b00) $display("FAIL rstmid_gnt: got %b want 00", gnt_o); else n_pass++;
        rst_i = 0; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        #1;
        n_total++; if (gnt_o !== 2'b01) $display("FAIL rstmid_tie: got %b want 01", gnt_o); else n_pass++;
        clear_inputs();
        step();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int errs;
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (m0_err_o) errs++;
            n_total++; if (s_stb_o !== 1'b1) $display("FAIL to_stall_stb %0d: got %b want 1", i, s_stb_o); else n_pass++;
            step();
        end
        #1;
        n_total++; if (errs !== 0) $display("FAIL to_early_err: got %0d want 0", errs); else n_pass++;
        n_total++;
        if ({m0_err_o, m0_ack_o, s_stb_o} !== 3'b100)
            $display("FAIL to_err_pulse: got %b want 100", {m0_err_o, m0_ack_o, s_stb_o});
        else n_pass++;
        step();
        #1;
        n_total++;
        if ({m0_err_o, s_stb_o, gnt_o} !== 4'b0001)
            $display("FAIL to_masked: got %b want 0001", {m0_err_o, s_stb_o, gnt_o});
        else n_pass++;
        m0_stb_i = 0;
        step();
        m0_stb_i = 1;
        #1;
        n_total++; if (s_stb_o !== 1'b1) $display("FAIL to_unmask: got %b want 1", s_stb_o); else n_pass++;
        for (int i = 0; i < 8; i++) step();
        s_ack_i = 1;
        #1;
        n_total++;
        if ({m0_ack_o, m0_err_o} !== 2'b10) $display("FAIL to_ack_wins: got %b want 10", {m0_ack_o, m0_err_o});
        else n_pass++;
        step();
        s_ack_i = 0;
        #1;
        n_total++;
        if ({m0_err_o, s_stb_o} !== 2'b01) $display("FAIL to_after_ack: got %b want 01", {m0_err_o, s_stb_o});
        else n_pass++;
        clear_inputs();
        step();
    endtask
`endif

    initial begin
        clear_inputs();
        rst_i = 1;
        test_reset();
        test_single();
        test_tie();
        test_lock();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
